// File: rtl/plot_pkg.sv
// plot_pkg: shared coordinate widths, screen size, pixel record and clear-FSM states.
package plot_pkg;
  localparam int COORD_W = 8;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int PIX_COLOR_W = 3;
  typedef struct packed {
    logic [COORD_W-1:0]     x;
    logic [COORD_W-1:0]     y;
    logic [PIX_COLOR_W-1:0] color;
  } pixel_t;
  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} clr_state_t;
endpackage

// File: rtl/plot_fifo.sv
// plot_fifo: synchronous pixel FIFO with a combinational head output.
module plot_fifo
  import plot_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  pixel_t                  din_i,
  output pixel_t                  dout_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    full_o,
  output logic                    empty_o
);
  localparam int AW = $clog2(DEPTH);
  pixel_t        mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= push_i ? wr_q + 1'b1 : wr_q;
      rd_q  <= pop_i ? rd_q + 1'b1 : rd_q;
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
  always_ff @(posedge clk) if (push_i) mem_q[wr_q] <= din_i;
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/pixel_plot_queue.sv
// pixel_plot_queue: buffers processor pixel writes and replays them to the framebuffer,
// with a sequencer that sweeps the whole frame in one colour between queued pixels.
module pixel_plot_queue
  import plot_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int WIDTH   = SCREEN_W,
  parameter int HEIGHT  = SCREEN_H,
  parameter int COLOR_W = PIX_COLOR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               plot_in,
  input  logic               clear_req,
  input  logic [COLOR_W-1:0] clear_color,
  output logic [COORD_W-1:0] fb_x,
  output logic [COORD_W-1:0] fb_y,
  output logic [COLOR_W-1:0] fb_color,
  output logic               fb_we,
  input  logic               fb_ready,
  output logic               full,
  output logic               busy,
  output logic               overflow
);
  localparam int CW = $clog2(DEPTH);
  clr_state_t         state_q, state_d;
  logic [COORD_W-1:0] fb_x_q, fb_x_d, fb_y_q, fb_y_d;
  logic [COLOR_W-1:0] fb_c_q, fb_c_d, clr_c_q, clr_c_d;
  logic               fb_we_q, fb_we_d, ovf_q, ovf_d;
  pixel_t             din, head;
  logic [CW:0]        fifo_cnt, total;
  logic               fifo_full, fifo_empty, staged, xfer, legal, push, load, pop, row_end, last;
  assign din = '{x: x_in, y: y_in, color: color_in};
  plot_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push_i(push), .pop_i(pop), .din_i(din), .dout_o(head),
    .count_o(fifo_cnt), .full_o(fifo_full), .empty_o(fifo_empty)
  );
  // Occupancy counts the staged queued pixel, so capacity is DEPTH including the output stage.
  assign xfer    = fb_we_q & fb_ready;
  assign staged  = fb_we_q & (state_q != CLEAR);
  assign total   = fifo_cnt + (CW+1)'(staged);
  assign legal   = plot_in & (x_in < COORD_W'(WIDTH)) & (y_in < COORD_W'(HEIGHT));
  assign push    = legal & ((total < (CW+1)'(DEPTH)) | (xfer & staged)) & (~fifo_full | pop);
  assign load    = (state_q == IDLE) & (~fb_we_q | xfer);
  assign pop     = load & ~fifo_empty;
  assign row_end = fb_x_q == COORD_W'(WIDTH-1);
  assign last    = row_end & (fb_y_q == COORD_W'(HEIGHT-1));
  // During CLEAR the fb_x/fb_y registers double as the sweep counters.
  always_comb begin
    state_d = state_q;
    fb_x_d  = pop ? head.x : fb_x_q;
    fb_y_d  = pop ? head.y : fb_y_q;
    fb_c_d  = pop ? head.color : fb_c_q;
    fb_we_d = fb_we_q;
    clr_c_d = clr_c_q;
    ovf_d   = ovf_q | (legal & ~push);
    case (state_q)
      IDLE: begin
        fb_we_d = load ? ~fifo_empty : fb_we_q;
        state_d = clear_req ? DRAIN : IDLE;
        clr_c_d = clear_req ? clear_color : clr_c_q;
      end
      DRAIN: begin
        fb_we_d = ~fb_we_q | ~fb_ready;
        state_d = fb_we_q ? DRAIN : CLEAR;
        fb_x_d  = fb_we_q ? fb_x_q : '0;
        fb_y_d  = fb_we_q ? fb_y_q : '0;
        fb_c_d  = fb_we_q ? fb_c_q : clr_c_q;
      end
      CLEAR: begin
        fb_x_d  = ~xfer ? fb_x_q : row_end ? '0 : fb_x_q + 1'b1;
        fb_y_d  = (xfer & row_end) ? fb_y_q + 1'b1 : fb_y_q;
        fb_we_d = ~(xfer & last);
        state_d = (xfer & last) ? IDLE : CLEAR;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      fb_x_q  <= '0;
      fb_y_q  <= '0;
      fb_c_q  <= '0;
      fb_we_q <= 1'b0;
      clr_c_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fb_x_q  <= fb_x_d;
      fb_y_q  <= fb_y_d;
      fb_c_q  <= fb_c_d;
      fb_we_q <= fb_we_d;
      clr_c_q <= clr_c_d;
      ovf_q   <= ovf_d;
    end
  end
  assign fb_x     = fb_x_q;
  assign fb_y     = fb_y_q;
  assign fb_color = fb_c_q;
  assign fb_we    = fb_we_q;
  assign full     = total == (CW+1)'(DEPTH);
  assign busy     = state_q != IDLE;
  assign overflow = ovf_q;
endmodule
